// File: rtl/updown_counter.sv
// Parametrised up/down counter with synchronous clear/load, wrap or saturate at the bounds,
// a registered terminal-count pulse and a sticky overflow flag.
module updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             up_dn,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxV = MAX_VAL[WIDTH-1:0];
  localparam logic [WIDTH-1:0] One  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  // Priority is clear > load > enable; tc is only ever set by a bound event on this step.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      cnt_d = (load_val > MaxV) ? MaxV : load_val;
    end else if (enable) begin
      if (up_dn) begin
        if (cnt_q >= MaxV) begin
          cnt_d = SATURATE ? MaxV : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + One;
        end
      end else begin
        if (cnt_q == '0) begin
          cnt_d = SATURATE ? '0 : MaxV;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q - One;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign out = cnt_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Directed bench for updown_counter: three instances (full-range wrap, modulus-10 wrap,
// full-range saturate) share one set of inputs; each test checks the relevant instance.
module tb_updown_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear, load, enable, up_dn;
  logic [3:0] load_val;

  logic [3:0] outW, outM, outS;
  logic       tcW, tcM, tcS;
  logic       ovfW, ovfM, ovfS;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(4)) uWrap (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn), .out(outW), .tc(tcW), .ovf(ovfW)
  );

  updown_counter #(.WIDTH(4), .MAX_VAL(9)) uMod (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn), .out(outM), .tc(tcM), .ovf(ovfM)
  );

  updown_counter #(.WIDTH(4), .SATURATE(1'b1)) uSat (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .load_val(load_val),
    .enable(enable), .up_dn(up_dn), .out(outS), .tc(tcS), .ovf(ovfS)
  );

  task automatic applyStimulus(input logic clr, input logic ld, input logic [3:0] lv,
                               input logic en, input logic ud);
    clear    = clr;
    load     = ld;
    load_val = lv;
    enable   = en;
    up_dn    = ud;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    #1;
    checkOutput("init out", 32'(outW), 32'd0);
    checkOutput("init tc", 32'(tcW), 32'd0);
    checkOutput("init ovf", 32'(ovfW), 32'd0);
    #2 reset = 1'b1;

    // Test 1: asynchronous reset mid-count
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 9; i++) tick();
    checkOutput("t1 out before reset", 32'(outW), 32'd9);
    #2 reset = 1'b0;
    #1;
    checkOutput("t1 out async", 32'(outW), 32'd0);
    checkOutput("t1 tc async", 32'(tcW), 32'd0);
    checkOutput("t1 ovf async", 32'(ovfW), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t1 out held %0d", i), 32'(outW), 32'd0);
    end
    #2 reset = 1'b1;

    // Test 2: full-range up wrap
    for (int i = 1; i <= 16; i++) begin
      tick();
      checkOutput($sformatf("t2 out %0d", i), 32'(outW), 32'(i % 16));
      checkOutput($sformatf("t2 tc %0d", i), 32'(tcW), (i == 16) ? 32'd1 : 32'd0);
      checkOutput($sformatf("t2 ovf %0d", i), 32'(ovfW), (i == 16) ? 32'd1 : 32'd0);
    end

    // Test 3: modulus-10 down wrap then up wrap
    applyStimulus(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
    tick();
    checkOutput("t3 cleared", 32'(outM), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    checkOutput("t3 down out", 32'(outM), 32'd9);
    checkOutput("t3 down tc", 32'(tcM), 32'd1);
    checkOutput("t3 down ovf", 32'(ovfM), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      checkOutput($sformatf("t3 up out %0d", k), 32'(outM), 32'((k - 1) % 10));
      checkOutput($sformatf("t3 up tc %0d", k), 32'(tcM),
                  (k == 1 || k == 11) ? 32'd1 : 32'd0);
    end

    // Test 4: saturate at both bounds
    applyStimulus(1'b0, 1'b1, 4'd14, 1'b0, 1'b1);
    tick();
    checkOutput("t4 load 14", 32'(outS), 32'd14);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    tick();
    checkOutput("t4 up1 out", 32'(outS), 32'd15);
    checkOutput("t4 up1 tc", 32'(tcS), 32'd0);
    tick();
    checkOutput("t4 up2 out", 32'(outS), 32'd15);
    checkOutput("t4 up2 tc", 32'(tcS), 32'd1);
    tick();
    checkOutput("t4 up3 out", 32'(outS), 32'd15);
    checkOutput("t4 up3 tc", 32'(tcS), 32'd1);
    checkOutput("t4 ovf", 32'(ovfS), 32'd1);
    applyStimulus(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    tick();
    checkOutput("t4 load 1", 32'(outS), 32'd1);
    checkOutput("t4 ovf kept by load", 32'(ovfS), 32'd1);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    tick();
    checkOutput("t4 dn1 out", 32'(outS), 32'd0);
    checkOutput("t4 dn1 tc", 32'(tcS), 32'd0);
    tick();
    checkOutput("t4 dn2 out", 32'(outS), 32'd0);
    checkOutput("t4 dn2 tc", 32'(tcS), 32'd1);

    // Test 5: priority clear > load > enable
    checkOutput("t5 ovf set before", 32'(ovfW), 32'd1);
    applyStimulus(1'b1, 1'b1, 4'd7, 1'b1, 1'b1);
    tick();
    checkOutput("t5 clear out", 32'(outW), 32'd0);
    checkOutput("t5 clear ovf", 32'(ovfW), 32'd0);
    applyStimulus(1'b0, 1'b1, 4'd7, 1'b1, 1'b1);
    tick();
    checkOutput("t5 load out", 32'(outW), 32'd7);
    checkOutput("t5 load tc", 32'(tcW), 32'd0);
    applyStimulus(1'b0, 1'b0, 4'd7, 1'b1, 1'b1);
    tick();
    checkOutput("t5 count out", 32'(outW), 32'd8);

    // Test 6: load clamp and hold
    applyStimulus(1'b0, 1'b1, 4'd13, 1'b0, 1'b1);
    tick();
    checkOutput("t6 clamp out", 32'(outM), 32'd9);
    checkOutput("t6 unclamped full range", 32'(outW), 32'd13);
    applyStimulus(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput($sformatf("t6 hold out %0d", i), 32'(outM), 32'd9);
      checkOutput($sformatf("t6 hold tc %0d", i), 32'(tcM), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
